// File: rtl/qsys_key_poller_if.sv
// Avalon-MM read port toward the key PIO plus the valid/ready key-event stream.
// The master modport is the poller side; the slave modport is the PIO/consumer side.
interface qsys_key_poller_if #(
  parameter int WIDTH = 4
) ();
  logic [1:0]       address;
  logic             read;
  logic             waitrequest;
  logic [31:0]      readdata;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_press;
  logic [WIDTH-1:0] evt_release;

  modport master (
    output address, read, evt_valid, evt_press, evt_release,
    input  waitrequest, readdata, evt_ready
  );

  modport slave (
    input  address, read, evt_valid, evt_press, evt_release,
    output waitrequest, readdata, evt_ready
  );
endinterface

// File: rtl/qsys_key_poller.sv
// Polls a key PIO over Avalon-MM, debounces the keys and queues press/release events.
// Optional macro QSYS_KEY_POLLER_IRQ_EN adds a registered irq output.
module qsys_key_poller #(
  parameter int WIDTH        = 4,
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 10,
  parameter int FIFO_DEPTH   = 4,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  qsys_key_poller_if.master  bus,
  output logic [WIDTH-1:0]   keys,
  output logic               overflow
`ifdef QSYS_KEY_POLLER_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int PCNT_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL} state_t;

  state_t              state, state_n;
  logic [PCNT_W-1:0]   poll_cnt;
  logic                expire;
  logic                read_c;
  logic [WIDTH-1:0]    samp;
  logic [WIDTH-1:0]    last;
  logic [DB_W-1:0]     db_cnt, db_cnt_n;
  logic                accept;
  logic [WIDTH-1:0]    press, release_c;
  logic [2*WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]    count, left;
  logic                pop, full, push_ok, drop;
  logic                unused_readdata;

  function automatic logic [WIDTH-1:0] to_pressed(input logic [WIDTH-1:0] raw);
    return (ACTIVE_LOW != 0) ? ~raw : raw;
  endfunction

  function automatic logic [DB_W-1:0] sat_inc(input logic [DB_W-1:0] c);
    return (c >= DB_W'(DEBOUNCE_CNT)) ? DB_W'(DEBOUNCE_CNT) : c + 1'b1;
  endfunction

  assign unused_readdata = ^bus.readdata[31:WIDTH];
  assign bus.address     = 2'd0;
  assign bus.read        = read_c;

  // Free-running poll timer; an expiry outside IDLE is simply lost.
  assign expire = (poll_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= PCNT_W'(POLL_DIV - 1);
      state    <= S_IDLE;
    end else begin
      poll_cnt <= expire ? PCNT_W'(POLL_DIV - 1) : poll_cnt - 1'b1;
      state    <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    read_c  = 1'b0;
    case (state)
      S_IDLE: if (expire) state_n = S_REQ;
      S_REQ: begin
        read_c = 1'b1;
        if (!bus.waitrequest) state_n = S_WAIT;
      end
      S_WAIT:  state_n = S_EVAL;
      S_EVAL:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Sample capture and FIFO storage carry no reset; both are qualified by control state.
  always_ff @(posedge clk) begin
    if (state == S_WAIT) samp <= to_pressed(bus.readdata[WIDTH-1:0]);
    if (push_ok) mem[wr_ptr] <= {press, release_c};
  end

  assign db_cnt_n  = (samp == last) ? sat_inc(db_cnt) : DB_W'(1);
  assign accept    = (state == S_EVAL) && (db_cnt_n == DB_W'(DEBOUNCE_CNT)) && (samp != keys);
  assign press     = samp & ~keys;
  assign release_c = ~samp & keys;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last   <= '0;
      db_cnt <= '0;
      keys   <= '0;
    end else if (state == S_EVAL) begin
      last   <= samp;
      db_cnt <= db_cnt_n;
      if (accept) keys <= samp;
    end
  end

  // Head registers show the entry left after this cycle's pop; a push becomes visible one cycle later.
  assign pop      = bus.evt_valid && bus.evt_ready;
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign push_ok  = accept && (!full || pop);
  assign drop     = accept && full && !pop;
  assign left     = count - CNT_W'(pop);
  assign rd_ptr_n = rd_ptr + PTR_W'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      overflow        <= 1'b0;
      bus.evt_valid   <= 1'b0;
      bus.evt_press   <= '0;
      bus.evt_release <= '0;
    end else begin
      wr_ptr          <= wr_ptr + PTR_W'(push_ok);
      rd_ptr          <= rd_ptr_n;
      count           <= count + CNT_W'(push_ok) - CNT_W'(pop);
      overflow        <= overflow | drop;
      bus.evt_valid   <= (left != '0);
      bus.evt_press   <= (left != '0) ? mem[rd_ptr_n][2*WIDTH-1:WIDTH] : '0;
      bus.evt_release <= (left != '0) ? mem[rd_ptr_n][WIDTH-1:0] : '0;
    end
  end

`ifdef QSYS_KEY_POLLER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= (left != '0) || overflow || drop;
  end
`endif

endmodule

// File: tb/tb_qsys_key_poller.sv
// Bench for qsys_key_poller: PIO read model, vector table and event scoreboard.
module tb_qsys_key_poller;
  logic       clk;
  logic       reset_n;
  logic [3:0] keys;
  logic       overflow;
  logic [3:0] in_port;
`ifdef QSYS_KEY_POLLER_IRQ_EN
  logic       irq;
`endif

  qsys_key_poller_if #(.WIDTH(4)) bus ();

  qsys_key_poller #(
    .WIDTH(4), .POLL_DIV(8), .DEBOUNCE_CNT(3), .FIFO_DEPTH(4), .ACTIVE_LOW(1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .keys     (keys),
    .overflow (overflow)
`ifdef QSYS_KEY_POLLER_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO s1 model: read data appears one cycle after an accepted read.
  always @(posedge clk) begin
    if (bus.read && !bus.waitrequest) bus.readdata <= {28'h0, in_port};
  end

  typedef struct packed {
    logic [3:0] press;
    logic [3:0] rel;
  } evt_t;

  typedef struct {
    logic [3:0] in_port;
    int         polls;
    logic [3:0] exp_keys;
    bit         has_evt;
    logic [3:0] press;
    logic [3:0] rel;
  } vec_t;

  evt_t sb[$];
  vec_t vecs[9];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every clock advance goes through here so a handshake is scored exactly once.
  task automatic step();
    evt_t e;
    if (bus.evt_valid && bus.evt_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%0h/%0h expected=none", bus.evt_press, bus.evt_release);
      end else begin
        e = sb.pop_front();
        chk("evt_press", bus.evt_press, e.press);
        chk("evt_release", bus.evt_release, e.rel);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_read(output int t);
    int n = 0;
    while (bus.read && n < 40) begin step(); n++; end
    while (!bus.read && n < 40) begin step(); n++; end
    if (!bus.read) begin
      checks++;
      failures++;
      $display("FAIL read_timeout actual=0 expected=1");
    end
    t = cyc;
  endtask

  // Returns in the IDLE cycle right after EVAL.
  task automatic poll();
    int t;
    wait_read(t);
    step();
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n;

    vecs[0] = '{4'hF, 1, 4'h1, 1'b0, 4'h0, 4'h0};
    vecs[1] = '{4'hE, 1, 4'h1, 1'b0, 4'h0, 4'h0};
    vecs[2] = '{4'hC, 2, 4'h1, 1'b0, 4'h0, 4'h0};
    vecs[3] = '{4'hC, 1, 4'h3, 1'b1, 4'h2, 4'h0};
    vecs[4] = '{4'h7, 3, 4'h8, 1'b1, 4'h8, 4'h3};
    vecs[5] = '{4'h0, 3, 4'hF, 1'b1, 4'h7, 4'h0};
    vecs[6] = '{4'hF, 3, 4'h0, 1'b1, 4'h0, 4'hF};
    vecs[7] = '{4'hE, 1, 4'h0, 1'b0, 4'h0, 4'h0};
    vecs[8] = '{4'hF, 3, 4'h0, 1'b0, 4'h0, 4'h0};

    reset_n         = 1'b0;
    in_port         = 4'hF;
    bus.waitrequest = 1'b0;
    bus.evt_ready   = 1'b0;
    repeat (3) step();
    chk("rst_read", bus.read, 1'b0);
    chk("rst_address", bus.address, 2'd0);
    chk("rst_evt_valid", bus.evt_valid, 1'b0);
    chk("rst_evt_press", bus.evt_press, 4'h0);
    chk("rst_evt_release", bus.evt_release, 4'h0);
    chk("rst_keys", keys, 4'h0);
    chk("rst_overflow", overflow, 1'b0);
`ifdef QSYS_KEY_POLLER_IRQ_EN
    chk("rst_irq", irq, 1'b0);
`endif
    reset_n = 1'b1;

    // Poll cadence with all keys released.
    wait_read(t0);
    for (int i = 0; i < 3; i++) begin
      wait_read(t1);
      chk("poll_period", t1 - t0, 8);
      chk("poll_address", bus.address, 2'd0);
      t0 = t1;
    end
    repeat (3) step();
    chk("idle_keys", keys, 4'h0);
    chk("idle_evt_valid", bus.evt_valid, 1'b0);

    // First press: accepted on the 3rd poll, event visible two cycles after EVAL.
    in_port = 4'hE;
    poll();
    poll();
    chk("press_wait_keys", keys, 4'h0);
    sb.push_back('{press: 4'h1, rel: 4'h0});
    wait_read(t0);
    step();
    step();
    step();
    chk("press_keys", keys, 4'h1);
    chk("press_valid_e1", bus.evt_valid, 1'b0);
    step();
    chk("press_valid_e2", bus.evt_valid, 1'b1);
    bus.evt_ready = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      in_port = vecs[i].in_port;
      if (vecs[i].has_evt) sb.push_back('{press: vecs[i].press, rel: vecs[i].rel});
      for (int p = 0; p < vecs[i].polls; p++) poll();
      chk($sformatf("vec%0d_keys", i), keys, vecs[i].exp_keys);
    end
    n = 0;
    while (sb.size() > 0 && n < 20) begin step(); n++; end
    chk("table_drain", sb.size(), 0);
    chk("table_overflow", overflow, 1'b0);

    // Five changes with the consumer stalled: four queue, the fifth is dropped.
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_port = (i % 2 == 0) ? 4'hE : 4'hF;
      if (i < 4) sb.push_back((i % 2 == 0) ? '{press: 4'h1, rel: 4'h0} : '{press: 4'h0, rel: 4'h1});
      repeat (3) poll();
      if (i == 3) chk("fill_no_overflow", overflow, 1'b0);
    end
    chk("full_overflow", overflow, 1'b1);
    chk("full_keys", keys, 4'h1);
    chk("full_head_press", bus.evt_press, 4'h1);
    chk("full_head_release", bus.evt_release, 4'h0);

    // Full FIFO with a pop in the push cycle: the new release event must survive.
    in_port = 4'hF;
    poll();
    poll();
    sb.push_back('{press: 4'h0, rel: 4'h1});
    wait_read(t0);
    step();
    step();
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
    chk("pushpop_keys", keys, 4'h0);
    chk("pushpop_sb_left", sb.size(), 4);
    step();
    bus.evt_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin step(); n++; end
    chk("pushpop_drain", sb.size(), 0);
    step();
    step();
    chk("drained_evt_valid", bus.evt_valid, 1'b0);
    chk("overflow_sticky", overflow, 1'b1);
`ifdef QSYS_KEY_POLLER_IRQ_EN
    chk("irq_sticky", irq, 1'b1);
`endif

    // Slave stall: REQ holds, the expiry during EVAL is skipped.
    wait_read(t0);
    bus.waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_read", bus.read, 1'b1);
      chk("stall_address", bus.address, 2'd0);
      step();
    end
    bus.waitrequest = 1'b0;
    wait_read(t1);
    chk("stall_next_req", t1 - t0, 16);
    chk("stall_keys", keys, 4'h0);

    // Reset asserted mid-request drops read without waiting for a clock.
    reset_n = 1'b0;
    #1;
    chk("async_rst_read", bus.read, 1'b0);
    chk("async_rst_overflow", overflow, 1'b0);
    step();
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
